// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, the timing record type and helpers
// that derive the total line/frame lengths from it.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  function automatic vga_axis_t vga_axis(input int active, fp, sync, bp);
    vga_axis_t a;
    a.active = 16'(active);
    a.fp     = 16'(fp);
    a.sync   = 16'(sync);
    a.bp     = 16'(bp);
    return a;
  endfunction

  function automatic int h_total(input vga_timing_t t);
    return int'(t.h.active) + int'(t.h.fp) + int'(t.h.sync) + int'(t.h.bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return int'(t.v.active) + int'(t.v.fp) + int'(t.v.sync) + int'(t.v.bp);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-advanced shift register of DEPTH stages; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int                DEPTH   = 1,
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en_i};
    assign q_o = d_i;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      end else if (en_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with latency-matched sync/blank and colour output.
// Optional internal 8-bar test pattern under `define VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [15:0]   x,
  output logic [15:0]   y,
  output logic          req,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          frame_start,
  output logic          line_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic          pat_sel
`endif
);

  localparam vga_timing_t TIM = '{h: vga_axis(H_ACTIVE, H_FP, H_SYNC, H_BP),
                                  v: vga_axis(V_ACTIVE, V_FP, V_SYNC, V_BP)};
  localparam int   H_TOTAL  = h_total(TIM);
  localparam int   V_TOTAL  = v_total(TIM);
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   HS_END   = HS_START + H_SYNC;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam int   VS_END   = VS_START + V_SYNC;
  localparam logic HS_ACT   = (HS_POL != 0);
  localparam logic VS_ACT   = (VS_POL != 0);
  localparam int   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_last;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic             raw_hs, raw_vs, raw_bn;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_d    = div_last ? '0 : div_q + 1'b1;
  assign pix_en   = div_last & ~rst;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_en) begin
      if (x_q == 16'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == 16'(V_TOTAL - 1)) ? '0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign raw_bn = (x_q < 16'(H_ACTIVE)) && (y_q < 16'(V_ACTIVE));
  assign raw_hs = ((x_q >= 16'(HS_START)) && (x_q < 16'(HS_END))) ? HS_ACT : ~HS_ACT;
  assign raw_vs = ((y_q >= 16'(VS_START)) && (y_q < 16'(VS_END))) ? VS_ACT : ~VS_ACT;

  assign x           = x_q;
  assign y           = y_q;
  assign req         = pix_en & raw_bn;
  assign line_start  = pix_en & (x_q == 16'd0);
  assign frame_start = line_start & (y_q == 16'd0);

  // Raw timing rides PIX_LAT stages here; the output register below is the last stage.
`ifdef VGA_TEST_PATTERN_EN
  localparam int DL_W = 6;
  localparam logic [DL_W-1:0] DL_RST = {~HS_ACT, ~VS_ACT, 4'b0000};
  logic [2:0] bar;
  assign bar = 3'((32'(x_q) * 32'd8) / 32'(H_ACTIVE));
`else
  localparam int DL_W = 3;
  localparam logic [DL_W-1:0] DL_RST = {~HS_ACT, ~VS_ACT, 1'b0};
`endif

  logic [DL_W-1:0] dl_d, dl_q;
  logic            dl_hs, dl_vs, dl_bn;

`ifdef VGA_TEST_PATTERN_EN
  assign dl_d = {raw_hs, raw_vs, raw_bn, bar};
`else
  assign dl_d = {raw_hs, raw_vs, raw_bn};
`endif

  vga_delay_line #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (DL_W),
    .RST_VAL (DL_RST)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en_i (pix_en),
    .d_i  (dl_d),
    .q_o  (dl_q)
  );

  assign dl_hs = dl_q[DL_W-1];
  assign dl_vs = dl_q[DL_W-2];
  assign dl_bn = dl_q[DL_W-3];

  logic [CW-1:0] src_r, src_g, src_b;
  logic [CW-1:0] r_d, g_d, b_d;
  logic [CW-1:0] r_q, g_q, b_q;
  logic          hs_q, vs_q, bn_q;

  always_comb begin
    src_r = r_in;
    src_g = g_in;
    src_b = b_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pat_sel) begin
      src_r = {CW{dl_q[2]}};
      src_g = {CW{dl_q[1]}};
      src_b = {CW{dl_q[0]}};
    end
`endif
    r_d = dl_bn ? src_r : '0;
    g_d = dl_bn ? src_g : '0;
    b_d = dl_bn ? src_b : '0;
  end

  // Output stage: sync, blank and colour leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= ~HS_ACT;
      vs_q <= ~VS_ACT;
      bn_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (pix_en) begin
      hs_q <= dl_hs;
      vs_q <= dl_vs;
      bn_q <= dl_bn;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign blank_n = bn_q;
  assign r_out   = r_q;
  assign g_out   = g_q;
  assign b_out   = b_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical widths in lines.
REQ-004 Parameter CLK_DIV, default 2, clk cycles per pixel (1..16).
REQ-005 Parameter PIX_LAT, default 2, pixel-source latency in pixel enables (0..8).
REQ-006 Parameter HS_POL, default 0, and VS_POL, default 0: sync active level.
REQ-007 Parameter CW, default 4, bits per colour channel.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 pix_en  out  1  one-clk pulse every CLK_DIV clks (constant 1 when CLK_DIV=1).
REQ-011 x, y  out  16 each  current raster counters, active region 0..H_ACTIVE-1 / 0..V_ACTIVE-1.
REQ-012 req  out  1  high when (x,y) is in the active region and pix_en is high.
REQ-013 r_in, g_in, b_in  in  CW each  colour from the pixel source, valid PIX_LAT pixel enables after req.
REQ-014 hsync, vsync, blank_n  out  1 each  registered, aligned with the colour outputs.
REQ-015 r_out, g_out, b_out  out  CW each  registered colour, forced to 0 when blank_n=0.
REQ-016 frame_start, line_start  out  1 each  one-clk pulses at (x,y)=(0,0) and at x=0, qualified by pix_en.
REQ-017 pat_sel  in  1  test-pattern select (present only under VGA_TEST_PATTERN_EN).

Function
REQ-018 Line order: active, front porch, sync, back porch; H_TOTAL = sum of the four; V_TOTAL likewise.
REQ-019 x advances only on pix_en; at x=H_TOTAL-1, x wraps to 0 and y increments; at y=V_TOTAL-1 with x wrap, y wraps to 0.
REQ-020 Raw hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; raw vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
REQ-021 Raw blank_n = (x < H_ACTIVE) and (y < V_ACTIVE).
REQ-022 Raw hsync, vsync and blank_n pass through a PIX_LAT+1 stage shift register advanced on pix_en, so output sync/blank align with r_in/g_in/b_in.
REQ-023 Colour outputs register on pix_en; they hold between enables.
REQ-024 A divider counter runs 0..CLK_DIV-1; pix_en asserts in the cycle the counter equals CLK_DIV-1.
REQ-025 Total latency from req to the matching r_out is PIX_LAT+1 pixel enables; hsync/vsync/blank_n share that latency exactly.

Reset
REQ-026 While rst=1: x=0, y=0, divider=0, pix_en=0, req=0, all delay stages hold inactive sync and blank_n=0, colour outputs=0, frame_start=0, line_start=0.
REQ-027 Inactive sync level = ~HS_POL / ~VS_POL; reset mid-frame aborts the frame, and the first pix_en after release is at (0,0) with frame_start=1.

Configuration
REQ-028 With VGA_TEST_PATTERN_EN defined and pat_sel=1, colour inputs are replaced by an internal 8-bar pattern: bar index = x*8/H_ACTIVE, colour bits {r,g,b} = bar index bits {2,1,0}, each channel all-ones or zero, same latency as the external path.
REQ-029 Without VGA_TEST_PATTERN_EN, pat_sel and the pattern logic are absent and colour always comes from r_in/g_in/b_in.

Structure
REQ-030 Package vga_pkg holds the default 640x480 timing constants, a timing-record typedef, and derived H_TOTAL/V_TOTAL functions.
REQ-031 Sub-module vga_delay_line (parameter depth and width, enable-advanced shift register) implements REQ-022 alignment.

Verification
REQ-032 Defaults, rst 3 cycles then run 2 frames -> 800 pixel enables per line, 525 lines, frame_start period 840000 clk.
REQ-033 Defaults -> hsync low for 96 pixel enables starting 656 enables after line_start, delayed 3 enables; vsync low for lines 490-491.
REQ-034 r_in driven with x[3:0] -> r_out at the first visible pixel equals 0 and increments each enable; r_out=0 whenever blank_n=0.
REQ-035 CLK_DIV=1, PIX_LAT=0, HS_POL=1 -> pix_en constant 1, hsync high-active, colour latency 1 clk.
REQ-036 rst asserted at (x,y)=(300,200) for 1 cycle -> next pix_en yields x=0, y=0, frame_start=1, sync inactive.
REQ-037 VGA_TEST_PATTERN_EN defined, pat_sel=1 -> pixel x=0 is black, x=560 gives r=g=b=4'hF, x=80 gives b only.
